// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multi-cycle RV32I datapath with one shared memory port.
// Adds a req/ready memory handshake, a wait-cycle watchdog and a retired-instruction counter.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 take_branch,
  input  logic                 mem_ready,
  output logic [2:0]           state,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 ir_write,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The counter never needs to hold more than MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT >= 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic                   r_fault;
  logic [CNT_WIDTH-1:0]   r_retired;

  logic                   w_pc_write;
  logic [1:0]             w_pc_src;
  logic                   w_ir_write;
  logic                   w_mem_req;
  logic                   w_mem_we;
  logic                   w_mem_addr_sel;
  logic                   w_reg_write;
  logic [1:0]             w_wb_sel;
  logic                   w_retire;
  logic                   w_set_fault;
  logic                   w_timeout;
  logic                   w_legal;

  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait_cnt == TIMEOUT_LAST);

  always_comb begin
    unique case (opcode)
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_LOAD,
      OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM: w_legal = 1'b1;
      default:                                         w_legal = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    w_next_state   = r_state;
    w_pc_write     = 1'b0;
    w_pc_src       = 2'd0;
    w_ir_write     = 1'b0;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_reg_write    = 1'b0;
    w_wb_sel       = 2'd0;
    w_retire       = 1'b0;
    w_set_fault    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write   = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_set_fault  = 1'b1;
          w_next_state = S_HALT;
        end
      end

      S_DECODE: begin
        if (w_legal) begin
          w_next_state = S_EXECUTE;
        end else begin
          w_set_fault  = 1'b1;
          w_next_state = S_HALT;
        end
      end

      S_EXECUTE: begin
        case (opcode)
          OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: w_next_state = S_WRITEBACK;
          OP_LOAD, OP_STORE:                 w_next_state = S_MEMORY;
          OP_BRANCH: begin
            w_pc_write   = 1'b1;
            w_pc_src     = take_branch ? 2'd1 : 2'd0;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            // Link is written from pc+4 of the current PC, which only updates at this edge.
            w_pc_write   = 1'b1;
            w_pc_src     = 2'd2;
            w_reg_write  = 1'b1;
            w_wb_sel     = 2'd2;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end
          OP_SYSTEM: begin
            w_retire     = 1'b1;
            w_next_state = S_HALT;
          end
          default: begin
            w_set_fault  = 1'b1;
            w_next_state = S_HALT;
          end
        endcase
      end

      S_MEMORY: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          w_pc_write   = 1'b1;
          w_retire     = 1'b1;
          w_next_state = S_FETCH;
          if (opcode == OP_LOAD) begin
            w_reg_write = 1'b1;
            w_wb_sel    = 2'd3;
          end
        end else if (w_timeout) begin
          w_set_fault  = 1'b1;
          w_next_state = S_HALT;
        end
      end

      S_WRITEBACK: begin
        w_reg_write  = 1'b1;
        w_wb_sel     = (opcode == OP_LUI) ? 2'd0 : 2'd1;
        w_pc_write   = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_HALT: w_next_state = S_HALT;

      default: begin
        w_set_fault  = 1'b1;
        w_next_state = S_HALT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_FETCH || r_state == S_MEMORY) && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (w_set_fault) begin
        r_fault <= 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
    end
  end

  // Decoded outputs are masked while reset is held so a pending access is dropped at once.
  assign state         = r_state;
  assign pc_write      = reset & w_pc_write;
  assign pc_src        = reset ? w_pc_src : 2'd0;
  assign ir_write      = reset & w_ir_write;
  assign mem_req       = reset & w_mem_req;
  assign mem_we        = reset & w_mem_we;
  assign mem_addr_sel  = reset & w_mem_addr_sel;
  assign reg_write     = reset & w_reg_write;
  assign wb_sel        = reset ? w_wb_sel : 2'd0;
  assign halted        = (r_state == S_HALT);
  assign fault         = r_fault;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT=4): walks each instruction class,
// memory waits, watchdog, illegal opcode, SYSTEM halt and asynchronous reset.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        take_branch;
  logic        mem_ready;
  logic [2:0]  state;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        halted;
  logic        fault;
  logic [31:0] retired_count;

  int passed = 0;
  int total  = 0;

  multicycle_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .take_branch(take_branch),
    .mem_ready(mem_ready), .state(state), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .reg_write(reg_write), .wb_sel(wb_sel),
    .halted(halted), .fault(fault), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] obs_ctl;
  assign obs_ctl = {pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel,
                    reg_write, wb_sel, halted, fault};

  function automatic logic [11:0] ctl(logic pcw, logic [1:0] pcs, logic irw, logic mreq,
                                      logic mwe, logic mas, logic rw, logic [1:0] wbs,
                                      logic hlt, logic flt);
    return {pcw, pcs, irw, mreq, mwe, mas, rw, wbs, hlt, flt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] c);
    check({tag, ".state"}, {29'd0, state}, {29'd0, st});
    check({tag, ".ctl"}, {20'd0, obs_ctl}, {20'd0, c});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expects a zero-wait FETCH now; leaves the bench in EXECUTE.
  task automatic fetch_decode(input string tag);
    mem_ready = 1'b1;
    #1;
    cyc({tag, ".fetch"}, 3'd0, ctl(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tick();
    cyc({tag, ".decode"}, 3'd1, '0);
    tick();
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    cyc(tag, 3'd0, '0);
    check({tag, ".count"}, retired_count, 32'd0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; opcode = 7'd0; take_branch = 1'b0; mem_ready = 1'b1;
    repeat (2) tick();
    cyc("rst", 3'd0, '0);
    check("rst.count", retired_count, 32'd0);

    // OP-IMM: 4 cycles
    reset = 1'b1; opcode = 7'b0010011;
    fetch_decode("alu");
    cyc("alu.exec", 3'd2, '0);
    tick();
    cyc("alu.wb", 3'd4, ctl(1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    check("alu.count_before", retired_count, 32'd0);
    tick();
    check("alu.state_after", {29'd0, state}, 32'd0);
    check("alu.count", retired_count, 32'd1);

    // Branch taken then not taken: 3 cycles each
    opcode = 7'b1100011; take_branch = 1'b1;
    fetch_decode("br_t");
    cyc("br_t.exec", 3'd2, ctl(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check("br_t.count", retired_count, 32'd2);
    take_branch = 1'b0;
    fetch_decode("br_nt");
    cyc("br_nt.exec", 3'd2, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check("br_nt.count", retired_count, 32'd3);

    // Load with three wait cycles in MEMORY
    opcode = 7'b0000011;
    fetch_decode("ld");
    cyc("ld.exec", 3'd2, '0);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("ld.wait%0d", i), 3'd3, ctl(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    cyc("ld.ready", 3'd3, ctl(1, 0, 0, 1, 0, 1, 1, 3, 0, 0));
    tick();
    check("ld.count", retired_count, 32'd4);

    // Store, zero wait
    opcode = 7'b0100011;
    fetch_decode("st");
    tick();
    cyc("st.mem", 3'd3, ctl(1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    tick();
    check("st.count", retired_count, 32'd5);

    // JAL
    opcode = 7'b1101111;
    fetch_decode("jal");
    cyc("jal.exec", 3'd2, ctl(1, 2, 0, 0, 0, 0, 1, 2, 0, 0));
    tick();
    check("jal.state_after", {29'd0, state}, 32'd0);
    check("jal.count", retired_count, 32'd6);

    // LUI writes back the immediate
    opcode = 7'b0110111;
    fetch_decode("lui");
    tick();
    cyc("lui.wb", 3'd4, ctl(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tick();
    check("lui.count", retired_count, 32'd7);

    // Fetch ready on the 4th wait cycle beats the watchdog
    opcode = 7'b1100011; take_branch = 1'b0; mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("fw.wait%0d", i), 3'd0, ctl(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    cyc("fw.last", 3'd0, ctl(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tick();
    cyc("fw.decode", 3'd1, '0);
    tick();
    tick();
    check("fw.count", retired_count, 32'd8);

    // Illegal opcode halts from DECODE without retiring
    opcode = 7'b0000000;
    #1;
    tick();
    cyc("ill.decode", 3'd1, '0);
    tick();
    cyc("ill.halt", 3'd5, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    check("ill.count", retired_count, 32'd8);
    tick();
    cyc("ill.hold", 3'd5, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

    // SYSTEM retires and halts cleanly
    reset_pulse("rst2");
    opcode = 7'b1110011;
    fetch_decode("sys");
    cyc("sys.exec", 3'd2, '0);
    tick();
    cyc("sys.halt", 3'd5, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("sys.count", retired_count, 32'd1);

    // Watchdog expiry in FETCH after exactly four wait cycles
    reset_pulse("rst3");
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc($sformatf("to.wait%0d", i + 1), 3'd0, ctl(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    end
    tick();
    mem_ready = 1'b1;
    #1;
    cyc("to.halt", 3'd5, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

    // Reset in the middle of a load access
    reset_pulse("rst4");
    opcode = 7'b1100011;
    fetch_decode("pre");
    tick();
    check("pre.count", retired_count, 32'd1);
    opcode = 7'b0000011;
    fetch_decode("ld2");
    mem_ready = 1'b0;
    tick();
    cyc("ld2.wait", 3'd3, ctl(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    reset = 1'b0;
    #1;
    cyc("mid_rst", 3'd0, '0);
    check("mid_rst.count", retired_count, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM that turns the RV32I datapath into a multi-cycle machine sharing one memory port between instruction fetch and load/store.
- Drives PC/IR write enables, memory address source, register write and write-back select from the latched opcode.
- Supports variable-latency memory through a req/ready handshake, with a timeout watchdog and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 255, number of consecutive wait cycles (mem_req=1, mem_ready=0) tolerated before fault; 0 disables the watchdog.
- CNT_WIDTH, 32, width of retired_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  instruction[6:0] from the IR; stable from DECODE onward.
- take_branch  input  1  branch condition result from the datapath, valid in EXECUTE.
- mem_ready  input  1  memory access complete; read data valid in the same cycle.
- state  output  3  FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
- pc_write  output  1  PC load strobe.
- pc_src  output  2  0=pc+4, 1=branch target, 2=alu_result.
- ir_write  output  1  IR load strobe.
- mem_req  output  1  memory access request.
- mem_we  output  1  store enable (qualified by mem_req).
- mem_addr_sel  output  1  0=PC, 1=alu_result.
- reg_write  output  1  register file write strobe.
- wb_sel  output  2  0=imm, 1=alu_result, 2=pc+4, 3=mem read data.
- halted  output  1  FSM is in HALT.
- fault  output  1  halt caused by illegal opcode or timeout.
- retired_count  output  CNT_WIDTH  instructions retired; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset low (asynchronous):
  - state=FETCH; wait counter, retired_count and fault cleared.
  - All strobes (pc_write, ir_write, mem_req, mem_we, reg_write) forced 0 while reset is low.
  - pc_src, wb_sel and mem_addr_sel read 0.
  - Reset mid-access abandons the access; no retire is counted.
- Outputs are combinational from state, opcode, take_branch and mem_ready. Unlisted outputs are 0.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - When mem_ready=1: ir_write=1 in that cycle, then go to DECODE. Otherwise hold.
- DECODE (1 cycle):
  - Legal opcodes: 0110011, 0010011, 0110111, 0010111, 0000011, 0100011, 1100011, 1101111, 1100111, 1110011.
  - Illegal opcode: go to HALT with fault=1, no retire. Otherwise go to EXECUTE.
- EXECUTE:
  - OP, OP-IMM, LUI, AUIPC: go to WRITEBACK.
  - LOAD, STORE: go to MEMORY.
  - BRANCH: pc_write=1, pc_src=take_branch?1:0, retire, go to FETCH.
  - JAL, JALR: pc_write=1, pc_src=2, reg_write=1, wb_sel=2, retire, go to FETCH. The link value uses the pre-update PC.
  - SYSTEM: retire, go to HALT with fault=0.
- WRITEBACK: reg_write=1, wb_sel=(LUI?0:1), pc_write=1, pc_src=0, retire, go to FETCH.
- MEMORY:
  - mem_req=1, mem_addr_sel=1, mem_we=(opcode==STORE).
  - Hold until mem_ready=1. On that cycle: pc_write=1, pc_src=0, retire, go to FETCH.
  - For LOAD, also reg_write=1, wb_sel=3 on that cycle only.
- HALT: all strobes 0; halted=1; state held until reset.
- Watchdog:
  - The wait counter increments each FETCH/MEMORY cycle with mem_ready=0, and clears on any state change.
  - If mem_ready=0 when the counter equals MEM_TIMEOUT-1, go to HALT with fault=1.
  - Exactly MEM_TIMEOUT wait cycles are tolerated. mem_ready on the final cycle wins over timeout.
- Retire: retired_count increments by 1 on the clock edge of each retiring cycle.
- Latency with zero-wait memory:
  - ALU/LUI/AUIPC/load/store: 4 cycles.
  - Branch/jump: 3 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Release reset, mem_ready=1, opcode=0010011 -> state 0,1,2,4,0. ir_write only in cycle 0; reg_write=1, wb_sel=1, pc_write=1, pc_src=0 only in cycle 3; retired_count=1 after 4 edges.
- opcode=1100011 with take_branch=1, then repeat with 0 -> EXECUTE asserts pc_write with pc_src=1, then pc_src=0; 3 cycles each; reg_write never asserted.
- opcode=0000011, mem_ready low for 3 cycles in MEMORY -> mem_req=1, mem_addr_sel=1, mem_we=0 for 4 cycles; reg_write=1 with wb_sel=3 only on the ready cycle. opcode=0100011 -> mem_we=1, reg_write=0.
- opcode=1101111 -> EXECUTE gives pc_write=1, pc_src=2, reg_write=1, wb_sel=2; next state FETCH.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> after 4 wait cycles state=5, halted=1, fault=1, all strobes 0. Ready on the 4th cycle instead -> normal DECODE.
- opcode=0000000 -> HALT from DECODE, fault=1, count unchanged.
- opcode=1110011 -> HALT, fault=0, count +1.
- reset low mid-MEMORY -> state=0, retired_count=0 immediately, strobes 0.
